id_stage: RTL and testbench

//  Decode stage of the 5-stage RV32I pipeline; consumes the fetch stage's registered pc/instr.

---
 rtl/id_stage_if.sv | 53 +++++
 rtl/id_stage.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_id_stage.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : id_stage_if
// Purpose  : Fetch/write-back inputs and ID/EX outputs of the decode stage.
// Revision : 1.0  initial release
// ============================================================================
interface id_stage_if;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        stall;
   logic        flush;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   logic        load_use;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic [31:0] ex_rs1_data;
   logic [31:0] ex_rs2_data;
   logic [31:0] ex_imm;
   logic [4:0]  ex_rs1;
   logic [4:0]  ex_rs2;
   logic [4:0]  ex_rd;
   logic [3:0]  ex_alu_op;
   logic        ex_alu_src;
   logic        ex_pc_src;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic        ex_reg_write;
   logic        ex_branch;
   logic        ex_jump;
   logic        ex_jalr;
   logic [2:0]  ex_funct3;
   logic        ex_illegal;

   modport master (
      output if_pc, if_instr, stall, flush, wb_we, wb_rd, wb_data,
      input  load_use, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
             ex_rs1, ex_rs2, ex_rd, ex_alu_op, ex_alu_src, ex_pc_src,
             ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_jump,
             ex_jalr, ex_funct3, ex_illegal
   );

   modport slave (
      input  if_pc, if_instr, stall, flush, wb_we, wb_rd, wb_data,
      output load_use, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
             ex_rs1, ex_rs2, ex_rd, ex_alu_op, ex_alu_src, ex_pc_src,
             ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_jump,
             ex_jalr, ex_funct3, ex_illegal
   );
endinterface
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_stage
// Purpose  : RV32I decode: regfile, immediate gen, control decode, load-use.
// Revision : 1.0  initial release
// ============================================================================
module id_stage #(
   parameter bit REG_RESET = 1'b1,
   parameter bit BYPASS_WB = 1'b1
) (
   input  wire logic  clk,
   input  wire logic  reset,
   id_stage_if.slave  bus_io
);

   localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
   localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
   localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
   localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
   localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] c_OPC_OP     = 7'b0110011;

   localparam logic [3:0] c_ALU_ADD   = 4'd0;
   localparam logic [3:0] c_ALU_SUB   = 4'd1;
   localparam logic [3:0] c_ALU_SLL   = 4'd2;
   localparam logic [3:0] c_ALU_SLT   = 4'd3;
   localparam logic [3:0] c_ALU_SLTU  = 4'd4;
   localparam logic [3:0] c_ALU_XOR   = 4'd5;
   localparam logic [3:0] c_ALU_SRL   = 4'd6;
   localparam logic [3:0] c_ALU_SRA   = 4'd7;
   localparam logic [3:0] c_ALU_OR    = 4'd8;
   localparam logic [3:0] c_ALU_AND   = 4'd9;
   localparam logic [3:0] c_ALU_PASSB = 4'd10;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [3:0]  alu_op;
      logic        alu_src;
      logic        pc_src;
      logic        mem_read;
      logic        mem_write;
      logic        reg_write;
      logic        branch;
      logic        jump;
      logic        jalr;
      logic [2:0]  funct3;
      logic        illegal;
   } idex_t;

   logic [31:0] rf_q [32];
   idex_t       idex_q;
   idex_t       idex_d;

   idex_t       w_dec;
   logic [31:0] w_instr;
   logic [6:0]  w_opcode;
   logic [4:0]  w_rd_f;
   logic [4:0]  w_rs1_f;
   logic [4:0]  w_rs2_f;
   logic [2:0]  w_funct3;
   logic [31:0] w_imm_i;
   logic [31:0] w_imm_s;
   logic [31:0] w_imm_b;
   logic [31:0] w_imm_u;
   logic [31:0] w_imm_j;
   logic [31:0] w_imm_sh;
   logic [3:0]  w_alu_arith;
   logic        w_use_rs1;
   logic        w_use_rs2;
   logic        w_use_rd;
   logic [4:0]  w_rs1_idx;
   logic [4:0]  w_rs2_idx;
   logic [4:0]  w_rd_idx;
   logic        w_bypass_en;
   logic [31:0] w_rs1_val;
   logic [31:0] w_rs2_val;
   logic        w_wb_hit;
   logic        w_load_use;

   assign w_instr  = bus_io.if_instr;
   assign w_opcode = w_instr[6:0];
   assign w_rd_f   = w_instr[11:7];
   assign w_funct3 = w_instr[14:12];
   assign w_rs1_f  = w_instr[19:15];
   assign w_rs2_f  = w_instr[24:20];

   assign w_imm_i  = {{20{w_instr[31]}}, w_instr[31:20]};
   assign w_imm_s  = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
   assign w_imm_b  = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                      w_instr[30:25], w_instr[11:8], 1'b0};
   assign w_imm_u  = {w_instr[31:12], 12'b0};
   assign w_imm_j  = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                      w_instr[20], w_instr[30:21], 1'b0};
   assign w_imm_sh = {27'b0, w_instr[24:20]};

   // instr[30] only means SUB for register-register ops; for shifts it means SRA/SRAI
   always_comb begin
      w_alu_arith = c_ALU_ADD;
      case (w_funct3)
         3'b000: w_alu_arith = (w_opcode == c_OPC_OP && w_instr[30]) ? c_ALU_SUB : c_ALU_ADD;
         3'b001: w_alu_arith = c_ALU_SLL;
         3'b010: w_alu_arith = c_ALU_SLT;
         3'b011: w_alu_arith = c_ALU_SLTU;
         3'b100: w_alu_arith = c_ALU_XOR;
         3'b101: w_alu_arith = w_instr[30] ? c_ALU_SRA : c_ALU_SRL;
         3'b110: w_alu_arith = c_ALU_OR;
         3'b111: w_alu_arith = c_ALU_AND;
      endcase
   end

   // alu_src is set for every format whose ALU B operand is the immediate
   always_comb begin
      w_dec        = '0;
      w_dec.valid  = 1'b1;
      w_dec.pc     = bus_io.if_pc - 32'd4;
      w_dec.funct3 = w_funct3;
      w_use_rs1    = 1'b0;
      w_use_rs2    = 1'b0;
      w_use_rd     = 1'b0;
      case (w_opcode)
         c_OPC_LUI: begin
            w_dec.alu_op  = c_ALU_PASSB;
            w_dec.alu_src = 1'b1;
            w_dec.imm     = w_imm_u;
            w_use_rd      = 1'b1;
         end
         c_OPC_AUIPC: begin
            w_dec.alu_op  = c_ALU_ADD;
            w_dec.alu_src = 1'b1;
            w_dec.pc_src  = 1'b1;
            w_dec.imm     = w_imm_u;
            w_use_rd      = 1'b1;
         end
         c_OPC_JAL: begin
            w_dec.jump    = 1'b1;
            w_dec.pc_src  = 1'b1;
            w_dec.alu_src = 1'b1;
            w_dec.imm     = w_imm_j;
            w_use_rd      = 1'b1;
         end
         c_OPC_JALR: begin
            w_dec.jump    = 1'b1;
            w_dec.jalr    = 1'b1;
            w_dec.alu_src = 1'b1;
            w_dec.imm     = w_imm_i;
            w_use_rs1     = 1'b1;
            w_use_rd      = 1'b1;
         end
         c_OPC_BRANCH: begin
            w_dec.branch  = 1'b1;
            w_dec.alu_op  = c_ALU_SUB;
            w_dec.imm     = w_imm_b;
            w_use_rs1     = 1'b1;
            w_use_rs2     = 1'b1;
         end
         c_OPC_LOAD: begin
            w_dec.mem_read = 1'b1;
            w_dec.alu_op   = c_ALU_ADD;
            w_dec.alu_src  = 1'b1;
            w_dec.imm      = w_imm_i;
            w_use_rs1      = 1'b1;
            w_use_rd       = 1'b1;
         end
         c_OPC_STORE: begin
            w_dec.mem_write = 1'b1;
            w_dec.alu_op    = c_ALU_ADD;
            w_dec.alu_src   = 1'b1;
            w_dec.imm       = w_imm_s;
            w_use_rs1       = 1'b1;
            w_use_rs2       = 1'b1;
         end
         c_OPC_OPIMM: begin
            w_dec.alu_op  = w_alu_arith;
            w_dec.alu_src = 1'b1;
            w_dec.imm     = (w_funct3 == 3'b001 || w_funct3 == 3'b101) ? w_imm_sh : w_imm_i;
            w_use_rs1     = 1'b1;
            w_use_rd      = 1'b1;
         end
         c_OPC_OP: begin
            w_dec.alu_op  = w_alu_arith;
            w_use_rs1     = 1'b1;
            w_use_rs2     = 1'b1;
            w_use_rd      = 1'b1;
         end
         default: begin
            w_dec.illegal = 1'b1;
         end
      endcase
   end

   assign w_rs1_idx = w_use_rs1 ? w_rs1_f : 5'd0;
   assign w_rs2_idx = w_use_rs2 ? w_rs2_f : 5'd0;
   assign w_rd_idx  = w_use_rd  ? w_rd_f  : 5'd0;

   generate
      if (BYPASS_WB) begin : g_bypass
         assign w_bypass_en = 1'b1;
      end else begin : g_no_bypass
         assign w_bypass_en = 1'b0;
      end
   endgenerate

   assign w_wb_hit = w_bypass_en && bus_io.wb_we;

   always_comb begin
      w_rs1_val = '0;
      w_rs2_val = '0;
      if (w_rs1_idx != 5'd0) begin
         w_rs1_val = (w_wb_hit && bus_io.wb_rd == w_rs1_idx) ? bus_io.wb_data : rf_q[w_rs1_idx];
      end
      if (w_rs2_idx != 5'd0) begin
         w_rs2_val = (w_wb_hit && bus_io.wb_rd == w_rs2_idx) ? bus_io.wb_data : rf_q[w_rs2_idx];
      end
   end

   assign w_load_use = idex_q.valid && idex_q.mem_read && (idex_q.rd != 5'd0) &&
                       ((w_use_rs1 && (w_rs1_f == idex_q.rd)) ||
                        (w_use_rs2 && (w_rs2_f == idex_q.rd)));

   always_comb begin
      idex_d = idex_q;
      if (bus_io.flush) begin
         idex_d = '0;
      end else if (bus_io.stall) begin
         idex_d = idex_q;
      end else if (w_load_use || (w_instr == 32'd0)) begin
         idex_d = '0;
      end else begin
         idex_d           = w_dec;
         idex_d.rs1       = w_rs1_idx;
         idex_d.rs2       = w_rs2_idx;
         idex_d.rd        = w_rd_idx;
         idex_d.reg_write = w_use_rd && (w_rd_f != 5'd0);
         idex_d.rs1_data  = w_rs1_val;
         idex_d.rs2_data  = w_rs2_val;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idex_q <= '0;
      end else begin
         idex_q <= idex_d;
      end
   end

   // Write-back is independent of stall/flush: it belongs to an older instruction
   generate
      if (REG_RESET) begin : g_rf_reset
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               for (int i = 0; i < 32; i++) begin
                  rf_q[i] <= '0;
               end
            end else if (bus_io.wb_we && (bus_io.wb_rd != 5'd0)) begin
               rf_q[bus_io.wb_rd] <= bus_io.wb_data;
            end
         end
      end else begin : g_rf_noreset
         always_ff @(posedge clk) begin
            if (bus_io.wb_we && (bus_io.wb_rd != 5'd0)) begin
               rf_q[bus_io.wb_rd] <= bus_io.wb_data;
            end
         end
      end
   endgenerate

   assign bus_io.load_use     = w_load_use;
   assign bus_io.ex_valid     = idex_q.valid;
   assign bus_io.ex_pc        = idex_q.pc;
   assign bus_io.ex_rs1_data  = idex_q.rs1_data;
   assign bus_io.ex_rs2_data  = idex_q.rs2_data;
   assign bus_io.ex_imm       = idex_q.imm;
   assign bus_io.ex_rs1       = idex_q.rs1;
   assign bus_io.ex_rs2       = idex_q.rs2;
   assign bus_io.ex_rd        = idex_q.rd;
   assign bus_io.ex_alu_op    = idex_q.alu_op;
   assign bus_io.ex_alu_src   = idex_q.alu_src;
   assign bus_io.ex_pc_src    = idex_q.pc_src;
   assign bus_io.ex_mem_read  = idex_q.mem_read;
   assign bus_io.ex_mem_write = idex_q.mem_write;
   assign bus_io.ex_reg_write = idex_q.reg_write;
   assign bus_io.ex_branch    = idex_q.branch;
   assign bus_io.ex_jump      = idex_q.jump;
   assign bus_io.ex_jalr      = idex_q.jalr;
   assign bus_io.ex_funct3    = idex_q.funct3;
   assign bus_io.ex_illegal   = idex_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_stage
// Purpose  : Self-checking bench for id_stage: vector table, corner sequences, random vs model.
// Revision : 1.0  initial release
// ============================================================================
module tb_id_stage;

   localparam bit BYPASS = 1'b1;

   localparam logic [6:0] OPC_LUI = 7'h37, OPC_AUIPC = 7'h17, OPC_JAL = 7'h6F, OPC_JALR = 7'h67;
   localparam logic [6:0] OPC_BR  = 7'h63, OPC_LOAD  = 7'h03, OPC_ST  = 7'h23, OPC_OPIMM = 7'h13;
   localparam logic [6:0] OPC_OP  = 7'h33;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   id_stage_if bus();

   id_stage #(.REG_RESET(1'b1), .BYPASS_WB(BYPASS)) dut (
      .clk    (clk),
      .reset  (reset),
      .bus_io (bus)
   );

   typedef struct packed {
      logic        valid;
      logic [31:0] pc, rs1_data, rs2_data, imm;
      logic [4:0]  rs1, rs2, rd;
      logic [3:0]  alu_op;
      logic        alu_src, pc_src, mem_read, mem_write, reg_write, branch, jump, jalr;
      logic [2:0]  funct3;
      logic        illegal;
   } ex_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] epc;
      logic [31:0] imm;
      logic [3:0]  alu;
      logic [7:0]  flags;
      logic        ill;
   } vec_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   ex_t         mq;
   logic [31:0] mrf [32];
   logic        last_lu;

   function automatic ex_t sample();
      ex_t a;
      a = '{bus.ex_valid, bus.ex_pc, bus.ex_rs1_data, bus.ex_rs2_data, bus.ex_imm,
            bus.ex_rs1, bus.ex_rs2, bus.ex_rd, bus.ex_alu_op, bus.ex_alu_src, bus.ex_pc_src,
            bus.ex_mem_read, bus.ex_mem_write, bus.ex_reg_write, bus.ex_branch, bus.ex_jump,
            bus.ex_jalr, bus.ex_funct3, bus.ex_illegal};
      return a;
   endfunction

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_ex_val(input string name, input ex_t exp);
      ex_t a;
      a = sample();
      n_checks++;
      if (a !== exp) begin
         n_fail++;
         $display("FAIL %s: ex got %h expected %h", name, a, exp);
      end
   endtask

   // Reference model: architectural rules stated directly
   function automatic logic [31:0] sx(input logic [31:0] raw, input int bits);
      return 32'($signed(raw << (32 - bits)) >>> (32 - bits));
   endfunction

   function automatic bit legal(input logic [6:0] o);
      return o inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BR, OPC_LOAD, OPC_ST, OPC_OPIMM, OPC_OP};
   endfunction
   function automatic bit uses_rs1(input logic [31:0] i);
      return legal(i[6:0]) && !(i[6:0] inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
   endfunction
   function automatic bit uses_rs2(input logic [31:0] i);
      return i[6:0] inside {OPC_OP, OPC_BR, OPC_ST};
   endfunction
   function automatic bit writes_rd(input logic [31:0] i);
      return legal(i[6:0]) && !(i[6:0] inside {OPC_BR, OPC_ST});
   endfunction

   function automatic logic [3:0] arith_op(input logic [2:0] f3, input bit sub, input bit sra);
      logic [3:0] tbl [8];
      tbl = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
      if (f3 == 3'd0 && sub) return 4'd1;
      if (f3 == 3'd5 && sra) return 4'd7;
      return tbl[f3];
   endfunction

   function automatic ex_t ref_decode(input logic [31:0] pc, input logic [31:0] i);
      ex_t e;
      e = '0;
      e.valid  = 1'b1;
      e.pc     = pc - 32'd4;
      e.funct3 = i[14:12];
      case (i[6:0])
         OPC_LUI:   begin e.imm = i & 32'hFFFF_F000; e.alu_op = 4'd10; e.alu_src = 1; end
         OPC_AUIPC: begin e.imm = i & 32'hFFFF_F000; e.alu_src = 1; e.pc_src = 1; end
         OPC_JAL:   begin
            e.imm = sx({i[31], i[19:12], i[20], i[30:21], 1'b0}, 21);
            e.alu_src = 1; e.pc_src = 1; e.jump = 1;
         end
         OPC_JALR:  begin e.imm = sx(i[31:20], 12); e.alu_src = 1; e.jump = 1; e.jalr = 1; end
         OPC_BR:    begin
            e.imm = sx({i[31], i[7], i[30:25], i[11:8], 1'b0}, 13);
            e.alu_op = 4'd1; e.branch = 1;
         end
         OPC_LOAD:  begin e.imm = sx(i[31:20], 12); e.alu_src = 1; e.mem_read = 1; end
         OPC_ST:    begin e.imm = sx({i[31:25], i[11:7]}, 12); e.alu_src = 1; e.mem_write = 1; end
         OPC_OPIMM: begin
            e.alu_src = 1;
            e.imm = (i[13:12] == 2'b01) ? 32'(i[24:20]) : sx(i[31:20], 12);
            e.alu_op = arith_op(i[14:12], 1'b0, i[30]);
         end
         OPC_OP:    e.alu_op = arith_op(i[14:12], i[30], i[30]);
         default:   e.illegal = 1'b1;
      endcase
      if (uses_rs1(i)) begin e.rs1 = i[19:15]; e.rs1_data = (e.rs1 == 0) ? 32'd0 : mrf[e.rs1]; end
      if (uses_rs2(i)) begin e.rs2 = i[24:20]; e.rs2_data = (e.rs2 == 0) ? 32'd0 : mrf[e.rs2]; end
      if (writes_rd(i)) begin e.rd = i[11:7]; e.reg_write = (e.rd != 0); end
      return e;
   endfunction

   function automatic logic model_lu(input logic [31:0] i);
      if (!(mq.valid && mq.mem_read && mq.rd != 5'd0)) return 1'b0;
      return (uses_rs1(i) && i[19:15] == mq.rd) || (uses_rs2(i) && i[24:20] == mq.rd);
   endfunction

   // One clock: apply inputs, check the combinational hazard, advance model, check ID/EX
   task automatic drive(input logic [31:0] pc, input logic [31:0] instr, input logic st,
                        input logic fl, input logic we, input logic [4:0] wrd,
                        input logic [31:0] wd, input string name);
      logic exp_lu;
      bus.if_pc = pc;  bus.if_instr = instr;
      bus.stall = st;  bus.flush = fl;
      bus.wb_we = we;  bus.wb_rd = wrd;  bus.wb_data = wd;
      #1;
      exp_lu  = model_lu(instr);
      last_lu = exp_lu;
      chk32({name, "/load_use"}, 32'(bus.load_use), 32'(exp_lu));
      @(posedge clk);
      if (BYPASS && we && wrd != 0) mrf[wrd] = wd;
      if (fl)                          mq = '0;
      else if (st)                     mq = mq;
      else if (exp_lu || instr == 0)   mq = '0;
      else                             mq = ref_decode(pc, instr);
      if (!BYPASS && we && wrd != 0) mrf[wrd] = wd;
      #1;
      chk_ex_val(name, mq);
   endtask

   function automatic logic [7:0] flags_now();
      return {bus.ex_alu_src, bus.ex_pc_src, bus.ex_mem_read, bus.ex_mem_write,
              bus.ex_reg_write, bus.ex_branch, bus.ex_jump, bus.ex_jalr};
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vt [13];
      ex_t         snap;
      logic [6:0]  opcs [11];
      logic [31:0] r_instr, r_pc;

      // flags = {alu_src, pc_src, mem_read, mem_write, reg_write, branch, jump, jalr}
      vt[0]  = '{32'hABCDE0B7, 32'h200, 32'h1FC, 32'hABCDE000, 4'd10, 8'h88, 1'b0}; // lui x1
      vt[1]  = '{32'hFE208EE3, 32'h104, 32'h100, 32'hFFFFFFFC, 4'd1,  8'h04, 1'b0}; // beq -4
      vt[2]  = '{32'hFFF00293, 32'h010, 32'h00C, 32'hFFFFFFFF, 4'd0,  8'h88, 1'b0}; // addi -1
      vt[3]  = '{32'h0020A423, 32'h020, 32'h01C, 32'h00000008, 4'd0,  8'h90, 1'b0}; // sw 8
      vt[4]  = '{32'h001000EF, 32'h030, 32'h02C, 32'h00000800, 4'd0,  8'hCA, 1'b0}; // jal x1
      vt[5]  = '{32'h00408067, 32'h040, 32'h03C, 32'h00000004, 4'd0,  8'h83, 1'b0}; // jalr x0
      vt[6]  = '{32'h4051D193, 32'h050, 32'h04C, 32'h00000005, 4'd7,  8'h88, 1'b0}; // srai
      vt[7]  = '{32'h402083B3, 32'h060, 32'h05C, 32'h00000000, 4'd1,  8'h08, 1'b0}; // sub
      vt[8]  = '{32'h00001517, 32'h070, 32'h06C, 32'h00001000, 4'd0,  8'hC8, 1'b0}; // auipc
      vt[9]  = '{32'hFFFFFFFF, 32'h080, 32'h07C, 32'h00000000, 4'd0,  8'h00, 1'b1}; // illegal
      vt[10] = '{32'h0000A183, 32'h090, 32'h08C, 32'h00000000, 4'd0,  8'hA8, 1'b0}; // lw x3
      vt[11] = '{32'hFFF0B213, 32'h0A0, 32'h09C, 32'hFFFFFFFF, 4'd4,  8'h88, 1'b0}; // sltiu
      vt[12] = '{32'h0000000F, 32'h0B0, 32'h0AC, 32'h00000000, 4'd0,  8'h00, 1'b1}; // fence

      opcs = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BR, OPC_LOAD, OPC_ST,
               OPC_OPIMM, OPC_OP, 7'h0F, 7'h7F};

      reset = 1'b1;
      bus.if_pc = '0; bus.if_instr = '0; bus.stall = 1'b0; bus.flush = 1'b0;
      bus.wb_we = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
      for (int i = 0; i < 32; i++) mrf[i] = '0;
      mq = '0;
      last_lu = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_ex_val("reset_state", '0);
      chk32("reset_load_use", 32'(bus.load_use), 32'd0);
      reset = 1'b0;

      for (int v = 0; v < 13; v++) begin
         drive(32'h0, 32'h0, 0, 0, 0, 5'd0, 32'h0, $sformatf("vec%0d_gap", v));
         drive(vt[v].pc, vt[v].instr, 0, 0, 0, 5'd0, 32'h0, $sformatf("vec%0d", v));
         chk32($sformatf("vec%0d_valid", v), 32'(bus.ex_valid), 32'd1);
         chk32($sformatf("vec%0d_illegal", v), 32'(bus.ex_illegal), 32'(vt[v].ill));
         chk32($sformatf("vec%0d_pc", v), bus.ex_pc, vt[v].epc);
         chk32($sformatf("vec%0d_imm", v), bus.ex_imm, vt[v].imm);
         chk32($sformatf("vec%0d_alu", v), 32'(bus.ex_alu_op), 32'(vt[v].alu));
         chk32($sformatf("vec%0d_flags", v), 32'(flags_now()), 32'(vt[v].flags));
      end

      // Same-cycle write-back forwarded into both operands
      drive(32'h300, 32'h0, 0, 0, 1, 5'd5, 32'hDEADBEEF, "wr_x5");
      drive(32'h304, 32'h00528333, 0, 0, 1, 5'd5, 32'h12345678, "bypass_add");
      chk32("bypass_rs1", bus.ex_rs1_data, 32'h12345678);
      chk32("bypass_rs2", bus.ex_rs2_data, 32'h12345678);
      chk32("bypass_alu", 32'(bus.ex_alu_op), 32'd0);
      drive(32'h308, 32'h00528333, 0, 0, 0, 5'd0, 32'h0, "reread_x5");
      chk32("reread_rs1", bus.ex_rs1_data, 32'h12345678);

      // Load-use: one bubble, then the dependent op decodes
      drive(32'h400, 32'h0000A183, 0, 0, 0, 5'd0, 32'h0, "lu_lw");
      drive(32'h404, 32'h00218233, 0, 0, 0, 5'd0, 32'h0, "lu_add_hold");
      chk32("lu_flag", 32'(last_lu), 32'd1);
      chk32("lu_bubble", 32'(bus.ex_valid), 32'd0);
      drive(32'h404, 32'h00218233, 0, 0, 0, 5'd0, 32'h0, "lu_add_go");
      chk32("lu_cleared", 32'(last_lu), 32'd0);
      chk32("lu_add_rd", 32'(bus.ex_rd), 32'd4);
      drive(32'h408, 32'h0000A003, 0, 0, 0, 5'd0, 32'h0, "lu_lw_x0");
      drive(32'h40C, 32'h00200233, 0, 0, 0, 5'd0, 32'h0, "lu_add_x0");
      chk32("lu_x0_nostall", 32'(last_lu), 32'd0);
      chk32("lu_x0_valid", 32'(bus.ex_valid), 32'd1);

      // Stall holds for three cycles; write-back continues underneath
      drive(32'h500, 32'hFFF00293, 0, 0, 0, 5'd0, 32'h0, "st_load");
      snap = sample();
      drive(32'h504, 32'h402083B3, 1, 0, 0, 5'd0, 32'h0, "st_1");
      chk_ex_val("st_hold1", snap);
      drive(32'h508, 32'hABCDE0B7, 1, 0, 1, 5'd7, 32'hCAFE0007, "st_2");
      chk_ex_val("st_hold2", snap);
      drive(32'h50C, 32'h0000A183, 1, 0, 0, 5'd0, 32'h0, "st_3");
      chk_ex_val("st_hold3", snap);
      drive(32'h510, 32'h402083B3, 1, 1, 0, 5'd0, 32'h0, "st_flush");
      chk32("st_flush_valid", 32'(bus.ex_valid), 32'd0);
      drive(32'h514, 32'h000383B3, 0, 0, 0, 5'd0, 32'h0, "st_wb_seen");
      chk32("st_wb_data", bus.ex_rs1_data, 32'hCAFE0007);

      // x0 is never written, even with a same-cycle write to it
      drive(32'h600, 32'h0, 0, 0, 1, 5'd0, 32'hFFFFFFFF, "x0_wr");
      drive(32'h604, 32'h00000333, 0, 0, 1, 5'd0, 32'hFFFFFFFF, "x0_rd");
      chk32("x0_rs1", bus.ex_rs1_data, 32'h0);
      chk32("x0_rs2", bus.ex_rs2_data, 32'h0);

      // Random traffic; upstream holds the instruction while load_use is raised
      r_instr = '0;
      r_pc    = '0;
      for (int n = 0; n < 400; n++) begin
         int sel;
         if (!last_lu) begin
            sel     = $urandom_range(0, 11);
            r_instr = $urandom;
            r_pc    = $urandom & 32'hFFFF_FFFC;
            if (sel == 11) begin
               r_instr = '0;
            end else begin
               r_instr[6:0]   = opcs[sel];
               r_instr[11:7]  = 5'($urandom_range(0, 7));
               r_instr[19:15] = 5'($urandom_range(0, 7));
               r_instr[24:20] = 5'($urandom_range(0, 7));
            end
         end
         drive(r_pc, r_instr, ($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0),
               $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
               $sformatf("rand%0d", n));
      end

      // Asynchronous reset in the middle of a cycle
      drive(32'h700, 32'hABCDE0B7, 0, 0, 1, 5'd5, 32'h55555555, "pre_reset");
      #3;
      reset = 1'b1;
      #1;
      mq = '0;
      for (int i = 0; i < 32; i++) mrf[i] = '0;
      chk_ex_val("reset_async", '0);
      chk32("reset_async_lu", 32'(bus.load_use), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive(32'h0, 32'h0, 0, 0, 0, 5'd0, 32'h0, "post_reset_zero");
      chk32("post_reset_valid", 32'(bus.ex_valid), 32'd0);
      drive(32'h804, 32'h00528333, 0, 0, 0, 5'd0, 32'h0, "post_reset_rf");
      chk32("post_reset_x5", bus.ex_rs1_data, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
